io_bridge: RTL and testbench

Memory-mapped responder at the far end of the CPU data bus (Bus_addr/Bus_rdata/Bus_wen/Bus_wdata). Decodes each access to either the data RAM or an on-chip I/O region, and owns the I/O peripherals: LED register, synchronised switch/button inputs, a prescaled 32-bit timer, and a multiplexed 8-digit seven-segment display scanner. Reads answer combinationally in the same cycle, matching the single-cycle core; writes commit on the cpu_clk rising edge.

---
 rtl/io_bridge_pkg.sv | 64 ++++++
 rtl/io_bridge_if.sv | 10 +
 rtl/io_bridge_seg_scan.sv | 39 +++
 rtl/io_bridge.sv | 137 +++++++++++++
 tb/tb_io_bridge.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bridge_pkg.sv
// Shared constants and helpers for the io_bridge CPU-bus responder:
// I/O region base, register offsets, select codes and the seven-segment table.
package io_bridge_pkg;

    localparam logic [19:0] IO_BASE     = 20'hFFFFF;

    localparam logic [11:0] OFF_DISPLAY = 12'h000;
    localparam logic [11:0] OFF_TCOUNT  = 12'h020;
    localparam logic [11:0] OFF_TDIV    = 12'h024;
    localparam logic [11:0] OFF_LED     = 12'h060;
    localparam logic [11:0] OFF_SW      = 12'h070;
    localparam logic [11:0] OFF_BTN     = 12'h078;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DISPLAY,
        SEL_TCOUNT,
        SEL_TDIV,
        SEL_LED,
        SEL_SW,
        SEL_BTN
    } io_sel_e;

    // Map a byte offset inside the I/O page to a register select; unmapped offsets give SEL_NONE.
    function automatic io_sel_e decode_io(input logic [11:0] off);
        io_sel_e sel;
        case (off)
            OFF_DISPLAY: sel = SEL_DISPLAY;
            OFF_TCOUNT:  sel = SEL_TCOUNT;
            OFF_TDIV:    sel = SEL_TDIV;
            OFF_LED:     sel = SEL_LED;
            OFF_SW:      sel = SEL_SW;
            OFF_BTN:     sel = SEL_BTN;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Active-low {DP,G,F,E,D,C,B,A} pattern for one hex digit, decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            4'hF:    s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU data-bus bundle: the core drives address/strobe/data, the bridge answers read data.
interface io_bridge_if;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;

    modport master (output Bus_addr, output Bus_wen, output Bus_wdata, input  Bus_rdata);
    modport slave  (input  Bus_addr, input  Bus_wen, input  Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/io_bridge_seg_scan.sv
// Eight-digit multiplexed seven-segment scanner: each digit stays lit for
// SCAN_CYCLES clocks, then the scan moves to the next nibble of the display word.
module seg_scan
    import io_bridge_pkg::*;
#(
    parameter int SCAN_CYCLES = 10000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] i_display,
    output logic [7:0]  o_dig_en,
    output logic [7:0]  o_seg
);

    localparam int               CNT_W     = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);

    logic [CNT_W-1:0] r_scan;
    logic [2:0]       r_idx;
    logic [3:0]       w_nibble;

    // Dwell counter; the digit index advances (mod 8) when the dwell period wraps.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_scan <= '0;
            r_idx  <= 3'd0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            r_idx  <= r_idx + 3'd1;
        end else begin
            r_scan <= r_scan + CNT_W'(1);
        end
    end

    assign w_nibble = i_display[{r_idx, 2'b00} +: 4];
    assign o_dig_en = ~(8'b0000_0001 << r_idx);
    assign o_seg    = hex_to_seg(w_nibble);

endmodule

// File: rtl/io_bridge.sv
// Far-end responder of the CPU data bus: routes accesses to data RAM or to the
// on-chip I/O page (LEDs, synchronised switches/buttons, prescaled timer, display).
// Reads are combinational; writes commit on the rising clock edge.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int          SCAN_CYCLES   = 10000,
    parameter logic [31:0] TIMER_DIV_RST = 32'd1000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    io_bridge_if.slave  bus,
    output logic [13:0] dram_addr,
    output logic        dram_we,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    logic        w_is_io;
    io_sel_e     w_sel;
    logic        w_io_wr;
    logic [31:0] w_div_eff;
    logic        w_tick;
    logic [31:0] w_rdata;

    logic [23:0] r_led;
    logic [31:0] r_display;
    logic [31:0] r_tcount;
    logic [31:0] r_tdiv;
    logic [31:0] r_presc;
    logic [23:0] r_sw_meta;
    logic [23:0] r_sw_sync;
    logic [4:0]  r_btn_meta;
    logic [4:0]  r_btn_sync;

    assign w_is_io = (bus.Bus_addr[31:12] == IO_BASE);
    assign w_sel   = w_is_io ? decode_io(bus.Bus_addr[11:0]) : SEL_NONE;
    assign w_io_wr = bus.Bus_wen & w_is_io;

    // RAM side is a pass-through; the strobe is suppressed for I/O addresses.
    assign dram_addr  = bus.Bus_addr[15:2];
    assign dram_we    = bus.Bus_wen & ~w_is_io;
    assign dram_wdata = bus.Bus_wdata;

    // A zero divider behaves like one, so the timer then counts every cycle.
    assign w_div_eff = (r_tdiv == 32'd0) ? 32'd1 : r_tdiv;
    assign w_tick    = (r_presc == (w_div_eff - 32'd1));

    // Combinational read mux: RAM data outside the I/O page, register data inside, zero for holes.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (!w_is_io) begin
            w_rdata = dram_rdata;
        end else begin
            case (w_sel)
                SEL_DISPLAY: w_rdata = r_display;
                SEL_TCOUNT:  w_rdata = r_tcount;
                SEL_TDIV:    w_rdata = r_tdiv;
                SEL_LED:     w_rdata = {8'h00, r_led};
                SEL_SW:      w_rdata = {8'h00, r_sw_sync};
                SEL_BTN:     w_rdata = {27'h0, r_btn_sync};
                default:     w_rdata = 32'h0000_0000;
            endcase
        end
    end

    assign bus.Bus_rdata = w_rdata;

    // LED and display registers take CPU writes to their offsets.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_led     <= 24'h00_0000;
            r_display <= 32'h0000_0000;
        end else begin
            if (w_io_wr && (w_sel == SEL_LED))     r_led     <= bus.Bus_wdata[23:0];
            if (w_io_wr && (w_sel == SEL_DISPLAY)) r_display <= bus.Bus_wdata;
        end
    end

    // Timer: prescaler divides the clock; a count write wins over a same-edge increment,
    // a divider write restarts the prescaler (an increment due on that edge still lands).
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_tcount <= 32'h0000_0000;
            r_tdiv   <= TIMER_DIV_RST;
            r_presc  <= 32'h0000_0000;
        end else begin
            if (w_io_wr && (w_sel == SEL_TDIV)) begin
                r_tdiv  <= bus.Bus_wdata;
                r_presc <= 32'h0000_0000;
            end else if (w_tick) begin
                r_presc <= 32'h0000_0000;
            end else begin
                r_presc <= r_presc + 32'd1;
            end

            if (w_io_wr && (w_sel == SEL_TCOUNT)) begin
                r_tcount <= bus.Bus_wdata;
            end else if (w_tick) begin
                r_tcount <= r_tcount + 32'd1;
            end
        end
    end

    // Two-flop synchronisers for the asynchronous switch and button inputs.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_sw_meta  <= 24'h00_0000;
            r_sw_sync  <= 24'h00_0000;
            r_btn_meta <= 5'h00;
            r_btn_sync <= 5'h00;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= button;
            r_btn_sync <= r_btn_meta;
        end
    end

    assign led = r_led;

    seg_scan #(
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_seg_scan (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .i_display (r_display),
        .o_dig_en  (dig_en),
        .o_seg     (seg)
    );

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: table-driven bus vectors plus hand-written
// sequences for synchronisers, timer, display scan and asynchronous reset.
module tb_io_bridge;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  button;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    int n_cmp = 0;
    int n_bad = 0;

    io_bridge_if bus_if ();

    io_bridge #(
        .SCAN_CYCLES   (4),
        .TIMER_DIV_RST (32'd1000)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .bus        (bus_if.slave),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .seg        (seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Small combinational-read RAM model behind the bridge.
    logic [31:0] ram [0:255] = '{default: 32'h0};
    assign dram_rdata = ram[dram_addr[7:0]];
    always @(posedge cpu_clk) begin
        if (dram_we) ram[dram_addr[7:0]] <= dram_wdata;
    end

    localparam logic [31:0] A_DISP = 32'hFFFF_F000;
    localparam logic [31:0] A_CNT  = 32'hFFFF_F020;
    localparam logic [31:0] A_DIV  = 32'hFFFF_F024;
    localparam logic [31:0] A_LED  = 32'hFFFF_F060;
    localparam logic [31:0] A_SW   = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN  = 32'hFFFF_F078;

    // Read-data scoreboard.
    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_we;
        logic [13:0] exp_daddr;
        logic [23:0] exp_led;
        string       name;
    } vec_t;
    vec_t vecs[16];

    logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_push(input string nm, input logic [31:0] exp);
        sb_q.push_back('{nm, exp});
    endtask

    task automatic sb_pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            chk(e.name, bus_if.Bus_rdata, e.exp);
        end
    endtask

    // Present a read at the falling edge and compare the combinational answer.
    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        @(negedge cpu_clk);
        bus_if.Bus_addr = addr;
        bus_if.Bus_wen  = 1'b0;
        sb_push(nm, exp);
        #1;
        sb_pop_check();
    endtask

    // Drive a write at the falling edge; it commits on the following rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge cpu_clk);
        bus_if.Bus_addr  = addr;
        bus_if.Bus_wdata = data;
        bus_if.Bus_wen   = 1'b1;
        @(posedge cpu_clk);
        #1;
        bus_if.Bus_wen = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
    endtask

    // Bounded wait for a digit-enable value, sampling just after rising edges.
    task automatic wait_dig(input logic [7:0] v, input string nm);
        int n = 0;
        while (dig_en !== v && n < 100) begin
            @(posedge cpu_clk);
            #1;
            n++;
        end
        chk(nm, {24'h0, dig_en}, {24'h0, v});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] exp_en;
        int         d;

        cpu_rst          = 1'b1;
        bus_if.Bus_addr  = 32'h0;
        bus_if.Bus_wen   = 1'b0;
        bus_if.Bus_wdata = 32'h0;
        sw               = 24'h0;
        button           = 5'h0;

        // Reset state
        #12;
        chk("rst_led", {8'h0, led}, 32'h0);
        chk("rst_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
        chk("rst_seg", {24'h0, seg}, 32'h0000_00C0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        bus_read(A_CNT, 32'h0, "rst_count");
        bus_read(A_DIV, 32'd1000, "rst_div");
        bus_read(A_DISP, 32'h0, "rst_display");

        // Table-driven bus vectors
        vecs[0]  = '{1'b1, A_LED,         32'h00AB_CDEF, 32'h0,         1'b0, 14'h3C18, 24'hABCDEF, "led_wr"};
        vecs[1]  = '{1'b0, A_LED,         32'h0,         32'h00AB_CDEF, 1'b0, 14'h3C18, 24'hABCDEF, "led_rd"};
        vecs[2]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0,         1'b1, 14'h0040, 24'hABCDEF, "ram_wr"};
        vecs[3]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678, 1'b0, 14'h0040, 24'hABCDEF, "ram_rd"};
        vecs[4]  = '{1'b1, 32'hFFFF_F044, 32'hDEAD_BEEF, 32'h0,         1'b0, 14'h3C11, 24'hABCDEF, "hole_wr"};
        vecs[5]  = '{1'b0, 32'hFFFF_F044, 32'h0,         32'h0,         1'b0, 14'h3C11, 24'hABCDEF, "hole_rd"};
        vecs[6]  = '{1'b0, 32'h0000_0104, 32'h0,         32'h0,         1'b0, 14'h0041, 24'hABCDEF, "ram_rd_empty"};
        vecs[7]  = '{1'b1, A_DISP,        32'h7654_3210, 32'h0,         1'b0, 14'h3C00, 24'hABCDEF, "disp_wr"};
        vecs[8]  = '{1'b0, A_DISP,        32'h0,         32'h7654_3210, 1'b0, 14'h3C00, 24'hABCDEF, "disp_rd"};
        vecs[9]  = '{1'b1, A_LED,         32'hFFFF_FFFF, 32'h0,         1'b0, 14'h3C18, 24'hFFFFFF, "led_wr2"};
        vecs[10] = '{1'b0, A_LED,         32'h0,         32'h00FF_FFFF, 1'b0, 14'h3C18, 24'hFFFFFF, "led_rd2"};
        vecs[11] = '{1'b1, 32'h0000_F060, 32'hCAFE_F00D, 32'h0,         1'b1, 14'h3C18, 24'hFFFFFF, "ram_alias_wr"};
        vecs[12] = '{1'b0, 32'h0000_F060, 32'h0,         32'hCAFE_F00D, 1'b0, 14'h3C18, 24'hFFFFFF, "ram_alias_rd"};
        vecs[13] = '{1'b1, A_SW,          32'h00FF_FFFF, 32'h0,         1'b0, 14'h3C1C, 24'hFFFFFF, "sw_wr_ignored"};
        vecs[14] = '{1'b0, A_SW,          32'h0,         32'h0,         1'b0, 14'h3C1C, 24'hFFFFFF, "sw_rd_zero"};
        vecs[15] = '{1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678, 1'b0, 14'h0040, 24'hFFFFFF, "ram_rd_kept"};

        for (int i = 0; i < 16; i++) begin
            @(negedge cpu_clk);
            bus_if.Bus_addr  = vecs[i].addr;
            bus_if.Bus_wdata = vecs[i].data;
            bus_if.Bus_wen   = vecs[i].wr;
            if (!vecs[i].wr) sb_push(vecs[i].name, vecs[i].exp_rd);
            #1;
            chk({vecs[i].name, "_we"}, {31'h0, dram_we}, {31'h0, vecs[i].exp_we});
            chk({vecs[i].name, "_daddr"}, {18'h0, dram_addr}, {18'h0, vecs[i].exp_daddr});
            if (!vecs[i].wr) sb_pop_check();
            @(posedge cpu_clk);
            #1;
            bus_if.Bus_wen = 1'b0;
            chk({vecs[i].name, "_led"}, {8'h0, led}, {8'h0, vecs[i].exp_led});
        end

        // Switch / button synchroniser latency
        @(negedge cpu_clk);
        sw     = 24'h00F00F;
        button = 5'h15;
        bus_if.Bus_addr = A_SW;
        sb_push("sw_edge0", 32'h0);
        #1;
        sb_pop_check();
        bus_read(A_BTN, 32'h0, "btn_edge1");
        bus_read(A_SW, 32'h0000_F00F, "sw_edge2");
        bus_read(A_BTN, 32'h0000_0015, "btn_edge3");

        // Timer: count near wrap, divider 3
        pulse_reset();
        bus_write(A_CNT, 32'hFFFF_FFFE);
        bus_write(A_DIV, 32'd3);
        for (int k = 0; k < 7; k++) begin
            bus_read(A_CNT, (k < 3) ? 32'hFFFF_FFFE : ((k < 6) ? 32'hFFFF_FFFF : 32'h0),
                     $sformatf("tmr_wrap_k%0d", k));
        end
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        bus_write(A_CNT, 32'd5);
        for (int j = 0; j < 4; j++) begin
            bus_read(A_CNT, (j < 3) ? 32'd5 : 32'd6, $sformatf("tmr_override_j%0d", j));
        end

        // Timer: divider 0 counts every cycle
        bus_write(A_DIV, 32'd0);
        bus_write(A_CNT, 32'd100);
        for (int j = 0; j < 3; j++) begin
            bus_read(A_CNT, 32'd100 + 32'(j), $sformatf("tmr_div0_j%0d", j));
        end

        // Display scan with 4-cycle dwell
        bus_write(A_DISP, 32'h7654_3210);
        wait_dig(8'h7F, "scan_sync_7f");
        wait_dig(8'hFE, "scan_sync_fe");
        for (int k = 0; k < 33; k++) begin
            d      = (k / 4) % 8;
            exp_en = 8'hFF ^ (8'h01 << d);
            chk($sformatf("scan_en_k%0d", k), {24'h0, dig_en}, {24'h0, exp_en});
            chk($sformatf("scan_seg_k%0d", k), {24'h0, seg}, {24'h0, seg_tab[d]});
            @(posedge cpu_clk);
            #1;
        end

        // Asynchronous reset mid-operation; the write in that cycle is lost
        bus_write(A_LED, 32'h00FF_FFFF);
        chk("pre_rst_led", {8'h0, led}, 32'h00FF_FFFF);
        @(negedge cpu_clk);
        #2;
        bus_if.Bus_addr  = A_LED;
        bus_if.Bus_wdata = 32'h0012_3456;
        bus_if.Bus_wen   = 1'b1;
        cpu_rst          = 1'b1;
        #1;
        chk("arst_led", {8'h0, led}, 32'h0);
        chk("arst_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
        chk("arst_seg", {24'h0, seg}, 32'h0000_00C0);
        @(posedge cpu_clk);
        #1;
        bus_if.Bus_wen  = 1'b0;
        bus_if.Bus_addr = A_CNT;
        sb_push("arst_count", 32'h0);
        #1;
        sb_pop_check();
        bus_if.Bus_addr = A_DIV;
        sb_push("arst_div", 32'd1000);
        #1;
        sb_pop_check();
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        bus_read(A_LED, 32'h0, "arst_write_lost");

        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
